// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream frame source.
package axis_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH  = 16;
  localparam int unsigned DEF_GAP_WIDTH  = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/axis_frame_source_if.sv
// AXI-Stream beat channel with master (driver) and slave (sink) views.
interface axis_frame_source_if
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_gap_counter.sv
// Loadable down-counter with a zero flag; paces the idle cycles between beats.
module axis_gap_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/axis_frame_source.sv
// AXI-Stream frame source: one frame of incrementing words per accepted command.
module axis_frame_source
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned GAP_WIDTH  = DEF_GAP_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_start,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  axis_frame_source_if.master   m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [CNT_WIDTH-1:0]  fc_q;

  logic accept;
  logic beat_hs;
  logic last_beat;
  logic frame_end;
  logic gap_load;
  logic gap_dec;
  logic gap_zero;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state handshake/gap control.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_nxt = (cfg_len == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        if (m_axis.tready) begin
          if (last_beat) begin
            state_nxt = FIN;
          end else if (gap_q != '0) begin
            state_nxt = GAP;
            gap_load  = 1'b1;
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          state_nxt = SEND;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept    = (state == IDLE) && cfg_valid;
  assign beat_hs   = (state == SEND) && m_axis.tready;
  assign last_beat = (idx_q == (len_q - LEN_WIDTH'(1)));
  // Counted on entry to FIN so frame_count already shows the new value while done is high.
  assign frame_end = (accept && (cfg_len == '0)) || (beat_hs && last_beat);

  // Command latch, beat index, data incrementer and completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      gap_q  <= '0;
      fc_q   <= '0;
    end else begin
      if (accept) begin
        len_q  <= cfg_len;
        gap_q  <= cfg_gap;
        data_q <= cfg_start;
        idx_q  <= '0;
      end else if (beat_hs && !last_beat) begin
        data_q <= data_q + DATA_WIDTH'(1);
        idx_q  <= idx_q + LEN_WIDTH'(1);
      end
      if (frame_end) begin
        fc_q <= fc_q + CNT_WIDTH'(1);
      end
    end
  end

  // Loaded with gap-1: the zero flag is seen in the last idle cycle, so GAP lasts exactly gap cycles.
  axis_gap_counter #(
    .WIDTH (GAP_WIDTH)
  ) u_gap_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q - GAP_WIDTH'(1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  assign m_axis.tvalid = (state == SEND);
  assign m_axis.tlast  = (state == SEND) && last_beat;
  assign m_axis.tdata  = data_q;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign frame_count   = fc_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: scoreboard of expected beats plus timing model.
module tb_axis_frame_source;
  import axis_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned GW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] cfg_start;
  logic [GW-1:0] cfg_gap;
  logic          busy;
  logic          done;
  logic [CW-1:0] frame_count;

  axis_frame_source_if #(.DATA_WIDTH(DW)) m_axis ();

  axis_frame_source #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .GAP_WIDTH  (GW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_len     (cfg_len),
    .cfg_start   (cfg_start),
    .cfg_gap     (cfg_gap),
    .m_axis      (m_axis),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [CW-1:0] exp_fc   = '0;

  // Drive one command for a single accept edge and queue the beats it should produce.
  task automatic send_cfg(input logic [LW-1:0] len, input logic [DW-1:0] start,
                          input logic [GW-1:0] gap, input bit keep_valid);
    beat_t b;
    for (int unsigned i = 0; i < 32'(len); i++) begin
      b.data = start + DW'(i);
      b.last = ((i + 1) == 32'(len));
      sb.push_back(b);
    end
    cfg_len   = len;
    cfg_start = start;
    cfg_gap   = gap;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    if (keep_valid) begin
      cfg_len   = len + LW'(3);
      cfg_start = start ^ DW'(8'hA5);
      cfg_gap   = gap + GW'(1);
    end else begin
      cfg_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    cfg_start = '0;
    cfg_gap   = '0;
    m_axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({m_axis.tvalid, m_axis.tlast, m_axis.tdata, busy, done, cfg_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_outputs: got v=%b l=%b d=%h busy=%b done=%b rdy=%b want v=0 l=0 d=00 busy=0 done=0 rdy=1",
               m_axis.tvalid, m_axis.tlast, m_axis.tdata, busy, done, cfg_ready);
    else n_pass++;
    n_checks++;
    if (frame_count !== '0) $display("FAIL reset_frame_count: got %0d want 0", frame_count);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({m_axis.tvalid, busy, done, cfg_ready} !== 4'b0001)
      $display("FAIL idle_after_reset: got v=%b busy=%b done=%b rdy=%b want 0/0/0/1", m_axis.tvalid, busy, done, cfg_ready);
    else n_pass++;
  endtask

  // Runs one frame from accept to done, checking every cycle against a timing model.
  task automatic test_stream(input string name, input logic [LW-1:0] len, input logic [DW-1:0] start,
                             input logic [GW-1:0] gap, input logic [DW-1:0] stall_data,
                             input int unsigned stall_n, input bit hold_cfg);
    int unsigned beats, gap_left, hold, cyc;
    bit          finished, exp_valid, exp_done;
    beat_t       exp;
    m_axis.tready = 1'b1;
    send_cfg(len, start, gap, hold_cfg);
    beats = 0; gap_left = 0; hold = 0; cyc = 0; finished = 0;
    while (!finished && cyc < 300) begin
      exp_valid = (beats < 32'(len)) && (gap_left == 0);
      exp_done  = (beats == 32'(len));
      n_checks++;
      if (m_axis.tvalid !== exp_valid)
        $display("FAIL %s_tvalid: cycle accept+%0d got %b want %b", name, cyc + 1, m_axis.tvalid, exp_valid);
      else n_pass++;
      n_checks++;
      if ({done, busy, cfg_ready} !== {exp_done, 1'b1, 1'b0})
        $display("FAIL %s_status: cycle accept+%0d got done=%b busy=%b rdy=%b want done=%b busy=1 rdy=0",
                 name, cyc + 1, done, busy, cfg_ready, exp_done);
      else n_pass++;
      m_axis.tready = 1'b1;
      if (m_axis.tvalid === 1'b1 && sb.size() > 0) begin
        exp = sb[0];
        n_checks++;
        if ({m_axis.tlast, m_axis.tdata} !== {exp.last, exp.data})
          $display("FAIL %s_beat: cycle accept+%0d got d=%h l=%b want d=%h l=%b",
                   name, cyc + 1, m_axis.tdata, m_axis.tlast, exp.data, exp.last);
        else n_pass++;
        if (m_axis.tdata === stall_data && hold < stall_n) begin
          m_axis.tready = 1'b0;
          hold++;
        end else begin
          void'(sb.pop_front());
          beats++;
          if (beats < 32'(len)) gap_left = 32'(gap);
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (exp_done && done === 1'b1) begin
        finished = 1;
        exp_fc   = exp_fc + CW'(1);
        cfg_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (!finished) $display("FAIL %s_timeout: got no done within %0d cycles want done", name, cyc);
    else n_pass++;
    n_checks++;
    if ({done, busy, cfg_ready, m_axis.tvalid} !== 4'b0010)
      $display("FAIL %s_idle_after: got done=%b busy=%b rdy=%b v=%b want 0/0/1/0", name, done, busy, cfg_ready, m_axis.tvalid);
    else n_pass++;
    n_checks++;
    if (frame_count !== exp_fc) $display("FAIL %s_frame_count: got %0d want %0d", name, frame_count, exp_fc);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0 || hold != stall_n)
      $display("FAIL %s_completeness: got %0d beats left, %0d stalls want 0 left, %0d stalls", name, sb.size(), hold, stall_n);
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_empty_frame();
    int unsigned dcount, first_k;
    bit          vseen;
    m_axis.tready = 1'b1;
    send_cfg('0, 8'h33, 8'h02, 1'b0);
    dcount = 0; first_k = 99; vseen = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (done === 1'b1) begin
        dcount++;
        if (first_k == 99) first_k = k;
      end
      if (m_axis.tvalid !== 1'b0) vseen = 1;
      @(posedge clk); #1;
    end
    exp_fc = exp_fc + CW'(1);
    n_checks++;
    if (dcount != 1 || first_k > 1)
      $display("FAIL empty_done: got %0d pulses first at accept+%0d want 1 pulse at accept+1..2", dcount, first_k + 1);
    else n_pass++;
    n_checks++;
    if (vseen) $display("FAIL empty_tvalid: got tvalid high want never");
    else n_pass++;
    n_checks++;
    if (frame_count !== exp_fc) $display("FAIL empty_frame_count: got %0d want %0d", frame_count, exp_fc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int unsigned k;
    m_axis.tready = 1'b1;
    send_cfg(16'd8, 8'h40, 8'h00, 1'b0);
    k = 0;
    while (!(m_axis.tvalid === 1'b1 && m_axis.tdata === 8'h43) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (k >= 20) $display("FAIL midreset_reach_beat3: got no beat 43 within 20 cycles want beat 43");
    else n_pass++;
    m_axis.tready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_fc = '0;
    n_checks++;
    if ({m_axis.tvalid, done, busy, cfg_ready} !== 4'b0001)
      $display("FAIL midreset_outputs: got v=%b done=%b busy=%b rdy=%b want 0/0/0/1", m_axis.tvalid, done, busy, cfg_ready);
    else n_pass++;
    n_checks++;
    if (frame_count !== '0) $display("FAIL midreset_frame_count: got %0d want 0", frame_count);
    else n_pass++;
    for (int unsigned j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({done, m_axis.tvalid} !== 2'b00)
        $display("FAIL midreset_quiet: got done=%b v=%b want 0/0", done, m_axis.tvalid);
      else n_pass++;
    end
    test_stream("after_reset", 16'd5, 8'h80, 8'h01, 8'h00, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream("basic", 16'd4, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    test_stream("backpressure", 16'd6, 8'h10, 8'h00, 8'h12, 4, 1'b0);
    test_stream("gap", 16'd3, 8'h20, 8'h02, 8'h00, 0, 1'b1);
    test_stream("single", 16'd1, 8'h55, 8'h03, 8'h00, 0, 1'b0);
    test_empty_frame();
    test_stream("wrap", 16'd4, 8'hFE, 8'h00, 8'h00, 0, 1'b0);
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
